spi_slave_ctrl: RTL

//  SPI slave front-end that sits directly upstream of the single-port SPI RAM.

---
 rtl/spi_slave_ctrl_pkg.sv | 16 +
 rtl/spi_slave_ctrl_if.sv | 14 +
 rtl/spi_slave_ctrl_tx_serializer.sv | 41 ++++
 rtl/spi_slave_ctrl.sv | 72 +++++++
 4 files changed

// File: rtl/spi_slave_ctrl_pkg.sv
// spi_slave_ctrl_pkg: shared types, widths and command check for the SPI slave front-end
package spi_slave_ctrl_pkg;
  localparam int MEM_WIDTH = 8;
  localparam int ADDR_SIZE = 8;
  localparam int WORD_W = MEM_WIDTH + 2;

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} spi_state_e;
  typedef enum logic [1:0] {WR_ADDR = 2'b00, WR_DATA = 2'b01, RD_ADDR = 2'b10, RD_DATA = 2'b11} ram_cmd_e;

  // A write frame may carry either write command; read frames must match their phase exactly.
  function automatic logic cmd_ok(spi_state_e st, logic [1:0] cmd);
    return st == WRITE ? !cmd[1] :
           st == READ_ADD ? cmd == RD_ADDR :
           st == READ_DATA ? cmd == RD_DATA : 1'b0;
  endfunction
endpackage

// File: rtl/spi_slave_ctrl_if.sv
// spi_slave_ctrl_if: SPI pins plus the RAM-side word/readback handshake
interface spi_slave_ctrl_if;
  import spi_slave_ctrl_pkg::*;
  logic ss_n;
  logic mosi;
  logic miso;
  logic [WORD_W-1:0] rx_data;
  logic rx_valid;
  logic [MEM_WIDTH-1:0] tx_data;
  logic tx_valid;
  logic frame_err;
  modport slave (input ss_n, mosi, tx_data, tx_valid, output miso, rx_data, rx_valid, frame_err);
  modport master (output ss_n, mosi, tx_data, tx_valid, input miso, rx_data, rx_valid, frame_err);
endinterface

// File: rtl/spi_slave_ctrl_tx_serializer.sv
// spi_tx_serializer: loads RAM read data and shifts it out MSB first, one bit per cycle
module spi_tx_serializer
  import spi_slave_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 load_i,
  input  logic [MEM_WIDTH-1:0] data_i,
  output logic                 miso_o,
  output logic                 done_o
);
  localparam logic [3:0] LAST = 4'(MEM_WIDTH - 1);
  logic [MEM_WIDTH-1:0] sh_q;
  logic [3:0] cnt_q;
  logic busy_q, miso_q, done_q;
  assign miso_o = miso_q;
  assign done_o = done_q;
  // MSB goes out on the load edge; after the last bit the line returns low and done is held.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      sh_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      miso_q <= 1'b0;
      done_q <= 1'b0;
    end else if (load_i) begin
      sh_q <= {data_i[MEM_WIDTH-2:0], 1'b0};
      cnt_q <= '0;
      busy_q <= 1'b1;
      miso_q <= data_i[MEM_WIDTH-1];
      done_q <= 1'b0;
    end else if (busy_q) begin
      miso_q <= cnt_q == LAST ? 1'b0 : sh_q[MEM_WIDTH-1];
      sh_q <= sh_q << 1;
      cnt_q <= cnt_q == LAST ? '0 : cnt_q + 4'd1;
      busy_q <= cnt_q != LAST;
      done_q <= cnt_q == LAST;
    end
  end
endmodule

// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: SPI slave front-end framing MOSI words for the SPI RAM and replaying read data on MISO
module spi_slave_ctrl
  import spi_slave_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  spi_slave_ctrl_if.slave bus
);
  localparam logic [3:0] LAST_BIT = 4'(WORD_W - 1);
  spi_state_e state_q;
  logic [3:0] cnt_q;
  logic [WORD_W-2:0] shift_q;
  logic [WORD_W-1:0] word_d, rx_data_q;
  logic done_q, rd_wait_q, rd_addr_seen_q, rx_valid_q, frame_err_q, tx_load_d, tx_done;
  assign word_d = {shift_q, bus.mosi};
  assign tx_load_d = state_q == READ_DATA && rd_wait_q && bus.tx_valid && !tx_done;
  assign bus.rx_data = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  // Frame FSM: command bit, ten word bits, then hold (done_q) until ss_n deasserts.
  always_ff @(posedge clk) begin
    rx_valid_q <= 1'b0;
    frame_err_q <= 1'b0;
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      shift_q <= '0;
      done_q <= 1'b0;
      rd_wait_q <= 1'b0;
      rx_data_q <= '0;
      rd_addr_seen_q <= 1'b0;
    end else if (bus.ss_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      done_q <= 1'b0;
      rd_wait_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: state_q <= CHK_CMD;
        CHK_CMD: state_q <= !bus.mosi ? WRITE : rd_addr_seen_q ? READ_DATA : READ_ADD;
        default: begin
          if (!done_q) begin
            shift_q <= word_d[WORD_W-2:0];
            cnt_q <= cnt_q == LAST_BIT ? '0 : cnt_q + 4'd1;
            if (cnt_q == LAST_BIT) begin
              done_q <= 1'b1;
              if (cmd_ok(state_q, word_d[WORD_W-1:WORD_W-2])) begin
                rx_valid_q <= 1'b1;
                rx_data_q <= word_d;
                rd_addr_seen_q <= state_q == READ_ADD ? 1'b1 : state_q == READ_DATA ? 1'b0 : rd_addr_seen_q;
                rd_wait_q <= state_q == READ_DATA;
              end else begin
                frame_err_q <= 1'b1;
              end
            end
          end else if (rd_wait_q && bus.tx_valid) begin
            rd_wait_q <= 1'b0;
          end
        end
      endcase
    end
  end
  spi_tx_serializer u_tx (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (bus.ss_n),
    .load_i (tx_load_d),
    .data_i (bus.tx_data),
    .miso_o (bus.miso),
    .done_o (tx_done)
  );
endmodule
